// File: rtl/mul_div_unit_if.sv
// ----------------------------------------------------------------------------
// mul_div_unit_if
//   Bundles the request/response signals of the iterative multiply/divide
//   unit so the EX stage and the unit share one connection.
//   Parameter N : operand width.
//   master modport (EX stage / hazard logic side):
//     drives start, op, signed_op, flush, inA, inB
//     observes busy, done, div_by_zero, hi, lo
//   slave modport (mul_div_unit side): the mirror image.
// ----------------------------------------------------------------------------
interface mul_div_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic         op;
  logic         signed_op;
  logic         flush;
  logic [N-1:0] inA;
  logic [N-1:0] inB;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, signed_op, flush, inA, inB,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, signed_op, flush, inA, inB,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit beside the ALU. One iteration per clock,
//   N iterations per operation; the result lands in HI/LO on the edge that
//   raises done. busy doubles as the IF/ID/PC stall request.
//
//   Ports:
//     clock : clock, all state on posedge
//     reset : asynchronous, active-low reset
//     io    : mul_div_unit_if.slave
//             start/op/signed_op/flush/inA/inB in,
//             busy/done/div_by_zero/hi/lo out (all registered)
//
//   op = 0 : HI:LO = inA * inB (full 2N-bit product)
//   op = 1 : LO = inA / inB, HI = inA % inB (restoring division)
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     defined   : signed_op = 1 treats operands as two's complement; the
//                 iteration runs on magnitudes and signs are fixed up on
//                 the final edge, so latency is unchanged.
//     undefined : signed_op is ignored, all operations are unsigned.
// ----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic           clock,
  input  logic           reset,
  mul_div_unit_if.slave  io
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  count_r, count_s;
  logic [2*N-1:0] acc_r, acc_s;     // mult: {partial, multiplier}; div: {rem, quotient}
  logic [N-1:0]   opnd_r, opnd_s;   // multiplicand or divisor
  logic           op_r, op_s;
  logic           zero_r, zero_s;   // divide by zero detected at start
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           dbz_r, dbz_s;
  logic [N-1:0]   hi_r, hi_s;
  logic [N-1:0]   lo_r, lo_s;

  logic           accept_s;
  logic [N-1:0]   mag_a_s, mag_b_s;
  logic [N:0]     add_s, rem_sh_s, diff_s;
  logic [2*N-1:0] step_s;
  logic [N-1:0]   res_hi_s, res_lo_s;

  // A start is taken only when no operation is in flight and no flush is pending.
  assign accept_s = io.start && !io.flush && (state_r != RUN);

`ifdef MULDIV_SIGNED_EN
  logic neg_a_s, neg_b_s;
  logic neg_x_r;    // product / quotient must be negated
  logic neg_rem_r;  // remainder follows the dividend sign

  assign neg_a_s = io.signed_op & io.inA[N-1];
  assign neg_b_s = io.signed_op & io.inB[N-1];
  assign mag_a_s = neg_a_s ? -io.inA : io.inA;
  assign mag_b_s = neg_b_s ? -io.inB : io.inB;

  // Sign fix-up flags captured with the operands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_x_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (accept_s) begin
      neg_x_r   <= neg_a_s ^ neg_b_s;
      neg_rem_r <= neg_a_s;
    end
  end

  // Final-edge sign fix-up of the last iteration's value.
  always_comb begin
    res_hi_s = step_s[2*N-1:N];
    res_lo_s = step_s[N-1:0];
    if (op_r) begin
      res_lo_s = neg_x_r   ? -step_s[N-1:0]   : step_s[N-1:0];
      res_hi_s = neg_rem_r ? -step_s[2*N-1:N] : step_s[2*N-1:N];
    end else begin
      {res_hi_s, res_lo_s} = neg_x_r ? -step_s : step_s;
    end
  end
`else
  logic signed_unused_s;

  assign signed_unused_s = io.signed_op;
  assign mag_a_s  = io.inA;
  assign mag_b_s  = io.inB;
  assign res_hi_s = step_s[2*N-1:N];
  assign res_lo_s = step_s[N-1:0];
`endif

  // One shift-add (multiply) or restoring shift-subtract (divide) iteration.
  always_comb begin
    add_s    = {1'b0, acc_r[2*N-1:N]} + (acc_r[0] ? {1'b0, opnd_r} : {(N+1){1'b0}});
    rem_sh_s = acc_r[2*N-1:N-1];
    diff_s   = rem_sh_s - {1'b0, opnd_r};
    if (op_r) begin
      // diff_s[N] set means the trial subtraction went negative: restore.
      if (diff_s[N]) begin
        step_s = {acc_r[2*N-2:0], 1'b0};
      end else begin
        step_s = {diff_s[N-1:0], acc_r[N-2:0], 1'b1};
      end
    end else begin
      step_s = {add_s, acc_r[N-1:1]};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    acc_s   = acc_r;
    opnd_s  = opnd_r;
    op_s    = op_r;
    zero_s  = zero_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    dbz_s   = dbz_r;
    hi_s    = hi_r;
    lo_s    = lo_r;

    if (io.flush) begin
      state_s = IDLE;
      busy_s  = 1'b0;
      count_s = {CW{1'b0}};
    end else if (accept_s) begin
      state_s = RUN;
      count_s = {CW{1'b0}};
      busy_s  = 1'b1;
      op_s    = io.op;
      dbz_s   = 1'b0;
      zero_s  = io.op && (io.inB == {N{1'b0}});
      if (io.op) begin
        acc_s  = {{N{1'b0}}, mag_a_s};
        opnd_s = mag_b_s;
      end else begin
        acc_s  = {{N{1'b0}}, mag_b_s};
        opnd_s = mag_a_s;
      end
    end else begin
      case (state_r)
        IDLE, DONE: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
        RUN: begin
          if (zero_r) begin
            // Divide by zero: no iterations, HI/LO untouched.
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            dbz_s   = 1'b1;
          end else begin
            acc_s   = step_s;
            count_s = count_r + CW'(1);
            if (count_r == CW'(N-1)) begin
              state_s = DONE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
              hi_s    = res_hi_s;
              lo_s    = res_lo_s;
            end else begin
              state_s = RUN;
            end
          end
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      acc_r   <= {(2*N){1'b0}};
      opnd_r  <= {N{1'b0}};
      op_r    <= 1'b0;
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      hi_r    <= {N{1'b0}};
      lo_r    <= {N{1'b0}};
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      acc_r   <= acc_s;
      opnd_r  <= opnd_s;
      op_r    <= op_s;
      zero_r  <= zero_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dbz_r   <= dbz_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
    end
  end

  assign io.busy        = busy_r;
  assign io.done        = done_r;
  assign io.div_by_zero = dbz_r;
  assign io.hi          = hi_r;
  assign io.lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed bench for mul_div_unit (N = 32). Inputs change on the falling
//   edge, outputs are sampled on the falling edge. Signed cases are compiled
//   in only when MULDIV_SIGNED_EN is defined; otherwise signed_op is shown
//   to be ignored.
// ----------------------------------------------------------------------------
module tb_mul_div_unit;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   lat;

  mul_div_unit_if #(.N(32)) io ();

  mul_div_unit #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: present a request for exactly one rising edge.
  task automatic issue(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
    io.start     = 1'b1;
    io.op        = o;
    io.signed_op = s;
    io.inA       = a;
    io.inB       = b;
    @(negedge clock);
    io.start     = 1'b0;
  endtask

  // Count falling edges until done; poke > 0 pulses a stray start at that count.
  task automatic wait_done(input int poke, output int n);
    n = 0;
    while (!io.done && n < 40) begin
      @(negedge clock);
      n++;
      if (poke > 0 && n == poke) begin
        io.start = 1'b1;
        io.op    = 1'b0;
        io.inA   = 32'd99;
        io.inB   = 32'd99;
      end else begin
        io.start = 1'b0;
      end
    end
    io.start = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    io.start     = 1'b0;
    io.op        = 1'b0;
    io.signed_op = 1'b0;
    io.flush     = 1'b0;
    io.inA       = 32'd0;
    io.inB       = 32'd0;
    reset        = 1'b0;
    #1;
    check("rst_busy", {63'd0, io.busy}, 64'd0);
    check("rst_done", {63'd0, io.done}, 64'd0);
    check("rst_hilo", {io.hi, io.lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 6*7 with a stray start while busy
    issue(1'b0, 1'b0, 32'd6, 32'd7);
    check("mul_busy", {63'd0, io.busy}, 64'd1);
    wait_done(5, lat);
    check("mul_lat", 64'(lat), 64'd32);
    check("mul_res", {io.hi, io.lo}, 64'd42);
    check("mul_busy_done", {63'd0, io.busy}, 64'd0);
    @(negedge clock);
    check("mul_pulse", {63'd0, io.done}, 64'd0);

    // largest unsigned product, then back-to-back divide from DONE
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat);
    check("max_lat", 64'(lat), 64'd32);
    check("max_res", {io.hi, io.lo}, 64'hFFFF_FFFE_0000_0001);
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    check("b2b_busy", {63'd0, io.busy}, 64'd1);
    wait_done(0, lat);
    check("div_lat", 64'(lat), 64'd32);
    check("div_res", {io.hi, io.lo}, {32'd2, 32'd14});
    check("div_dbz", {63'd0, io.div_by_zero}, 64'd0);
    @(negedge clock);

    // divide by zero: done one edge later, HI/LO retained
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    wait_done(0, lat);
    check("dbz_lat", 64'(lat), 64'd1);
    check("dbz_flag", {63'd0, io.div_by_zero}, 64'd1);
    check("dbz_hilo", {io.hi, io.lo}, {32'd2, 32'd14});
    @(negedge clock);
    check("dbz_pulse", {63'd0, io.done}, 64'd0);
    check("dbz_held", {63'd0, io.div_by_zero}, 64'd1);

    // flush at iteration 10 of 3*3, then 2*2 on the following edge
    issue(1'b0, 1'b0, 32'd3, 32'd3);
    check("dbz_clear", {63'd0, io.div_by_zero}, 64'd0);
    repeat (9) @(negedge clock);
    io.start = 1'b1;  // ignored while busy
    io.inA   = 32'd5;
    io.inB   = 32'd5;
    io.flush = 1'b1;
    @(negedge clock);
    io.flush = 1'b0;
    check("fl_busy", {63'd0, io.busy}, 64'd0);
    check("fl_done", {63'd0, io.done}, 64'd0);
    check("fl_hilo", {io.hi, io.lo}, {32'd2, 32'd14});
    issue(1'b0, 1'b0, 32'd2, 32'd2);
    wait_done(0, lat);
    check("fl_next_lat", 64'(lat), 64'd32);
    check("fl_next_res", {io.hi, io.lo}, 64'd4);
    @(negedge clock);

    // divide with nontrivial remainder
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_done(0, lat);
    check("div2_res", {io.hi, io.lo}, {32'h0000_000F, 32'h0FFF_FFFF});
    @(negedge clock);

`ifdef MULDIV_SIGNED_EN
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, lat);
    check("sdiv_lat", 64'(lat), 64'd32);
    check("sdiv_res", {io.hi, io.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clock);
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4);
    wait_done(0, lat);
    check("smul_res", {io.hi, io.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF4});
    @(negedge clock);
`else
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4);
    wait_done(0, lat);
    check("uns_ign_res", {io.hi, io.lo}, {32'h0000_0003, 32'hFFFF_FFF4});
    @(negedge clock);
`endif

    // asynchronous reset in the middle of an operation
    issue(1'b0, 1'b0, 32'd6, 32'd7);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, io.busy}, 64'd0);
    check("arst_done", {63'd0, io.done}, 64'd0);
    check("arst_hilo", {io.hi, io.lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    issue(1'b0, 1'b0, 32'd9, 32'd9);
    wait_done(0, lat);
    check("post_rst_res", {io.hi, io.lo}, 64'd81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
